// File: rtl/demux14_32_reg.sv
// Registered 1-to-4 word distributor: one-entry holding register per channel, valid/ready on every side.
// Optional per-channel accept counters are built when DEMUX14_32_STATS_EN is defined.
module demux14_32_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_select,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   // Handshake: a word moves when valid and ready are both high at a rising edge.
   // in_ready depends only on in_select, channel state and out_ready, never on in_valid.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];
   logic             accept;

   always_comb begin
      in_ready = (state_q[in_select] == ST_EMPTY) || out_ready[in_select];
      accept   = in_valid && in_ready;
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         // An accept to a FULL channel with out_ready high is a pass-through: no bubble.
         if (accept && (in_select == 2'(k))) begin
            state_d[k] = ST_FULL;
            data_d[k]  = in_data;
         end else if ((state_q[k] == ST_FULL) && out_ready[k]) begin
            state_d[k] = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= ST_EMPTY;
            data_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
      end
   end

   always_comb begin
      out_valid = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = (state_q[k] == ST_FULL);
      end
   end

   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];

`ifdef DEMUX14_32_STATS_EN
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = cnt_q[k];
         if (accept && (in_select == 2'(k))) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
   assign cnt3 = cnt_q[3];
`else
   assign cnt0 = '0;
   assign cnt1 = '0;
   assign cnt2 = '0;
   assign cnt3 = '0;
`endif

endmodule
